// File: rtl/alb.sv
// alb: registered 4-bit arithmetic/logic block with carry, overflow,
// negative and zero flags. All outputs update one clk edge after the
// inputs are sampled; reset clears every output register asynchronously.
// Build option: define ALB_CARRY_LOOKAHEAD_EN to use a carry-lookahead
// adder. When it is undefined, a ripple-carry chain is used. Results are
// bit-identical in both builds.
module alb (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] R_in,
    input  logic [3:0] S_in,
    input  logic       CI,
    input  logic [1:0] I,
    output logic [3:0] F_ALB,
    output logic       CO,
    output logic       VO,
    output logic       NO,
    output logic       ZO
);

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] sum;
    logic [4:0] c;

    logic [3:0] f_d, f_q;
    logic       co_d, co_q;
    logic       vo_d, vo_q;
    logic       no_d, no_q;
    logic       zo_d, zo_q;

    // Adder operands: S + R for I=10; S + ~R (subtract with borrow) for I=00.
    always_comb begin
        add_a = S_in;
        add_b = I[1] ? R_in : ~R_in;
    end

`ifdef ALB_CARRY_LOOKAHEAD_EN
    logic [3:0] g;
    logic [3:0] p;

    // Carry-lookahead adder: every carry is a flat function of g, p and CI.
    always_comb begin
        g    = add_a & add_b;
        p    = add_a ^ add_b;
        c[0] = CI;
        c[1] = g[0] | (p[0] & CI);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & CI);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & CI);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & CI);
        sum  = p ^ c[3:0];
    end
`else
    // Ripple-carry adder: a chain of four full adders.
    always_comb begin
        logic cy;
        cy   = CI;
        sum  = '0;
        c    = '0;
        c[0] = CI;
        for (int k = 0; k < 4; k++) begin
            sum[k] = add_a[k] ^ add_b[k] ^ cy;
            cy     = (add_a[k] & add_b[k]) | (cy & (add_a[k] ^ add_b[k]));
            c[k+1] = cy;
        end
    end
`endif

    // Operation select and flag generation. Logic ops ignore CI and clear CO/VO.
    always_comb begin
        f_d  = '0;
        co_d = 1'b0;
        vo_d = 1'b0;
        case (I)
            2'b00, 2'b10: begin
                f_d  = sum;
                co_d = c[4];
                vo_d = c[3] ^ c[4];
            end
            2'b01:   f_d = S_in ^ R_in;
            default: f_d = ~(S_in ^ R_in);
        endcase
        no_d = f_d[3];
        zo_d = (f_d == 4'h0);
    end

    // Output registers; reset clears them immediately and drops any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q  <= '0;
            co_q <= 1'b0;
            vo_q <= 1'b0;
            no_q <= 1'b0;
            zo_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            co_q <= co_d;
            vo_q <= vo_d;
            no_q <= no_d;
            zo_q <= zo_d;
        end
    end

    assign F_ALB = f_q;
    assign CO    = co_q;
    assign VO    = vo_q;
    assign NO    = no_q;
    assign ZO    = zo_q;

endmodule

// File: tb/tb_alb.sv
// tb_alb: directed-vector bench for alb. Each vector has its expected
// result written by hand as {F, CO, VO, NO, ZO}.
module tb_alb;

    logic       clk;
    logic       reset;
    logic [3:0] R_in;
    logic [3:0] S_in;
    logic       CI;
    logic [1:0] I;
    logic [3:0] F_ALB;
    logic       CO, VO, NO, ZO;

    int n_vec;
    int n_err;

    alb dut (
        .clk   (clk),
        .reset (reset),
        .R_in  (R_in),
        .S_in  (S_in),
        .CI    (CI),
        .I     (I),
        .F_ALB (F_ALB),
        .CO    (CO),
        .VO    (VO),
        .NO    (NO),
        .ZO    (ZO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {F_ALB, CO, VO, NO, ZO};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got {F,CO,VO,NO,ZO}=%h_%b expected %h_%b",
                     tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic [1:0] i, input logic [3:0] r, input logic [3:0] s,
                         input logic ci);
        I    = i;
        R_in = r;
        S_in = s;
        CI   = ci;
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic apply(input string tag, input logic [1:0] i, input logic [3:0] r,
                         input logic [3:0] s, input logic ci, input logic [7:0] exp);
        @(negedge clk);
        drive(i, r, s, ci);
        @(posedge clk);
        #1;
        check(tag, outs(), exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(2'b10, 4'h7, 4'h1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 8'h00);

        @(negedge clk);
        reset = 1'b0;

        //        tag            I      R     S     CI    {F,CO,VO,NO,ZO}
        apply("sub_4_2_ci1",   2'b00, 4'h2, 4'h4, 1'b1, {4'h2, 4'b1000});
        apply("xor_c_a",       2'b01, 4'hA, 4'hC, 1'b0, {4'h6, 4'b0000});
        apply("add_2_3",       2'b10, 4'h3, 4'h2, 1'b0, {4'h5, 4'b0000});
        apply("add_1_7_ovf",   2'b10, 4'h7, 4'h1, 1'b0, {4'h8, 4'b0110});
        apply("xnor_c_a",      2'b11, 4'hA, 4'hC, 1'b0, {4'h9, 4'b0010});
        apply("sub_1_1_ci0",   2'b00, 4'h1, 4'h1, 1'b0, {4'hF, 4'b0010});
        apply("sub_1_1_ci1",   2'b00, 4'h1, 4'h1, 1'b1, {4'h0, 4'b1001});
        apply("xor_zero_ci1",  2'b01, 4'h5, 4'h5, 1'b1, {4'h0, 4'b0001});
        apply("xnor_zero_ci1", 2'b11, 4'hF, 4'h0, 1'b1, {4'h0, 4'b0001});
        apply("add_wrap",      2'b10, 4'hF, 4'h1, 1'b0, {4'h0, 4'b1001});
        apply("add_neg_ovf",   2'b10, 4'h8, 4'h8, 1'b0, {4'h0, 4'b1101});
        apply("add_max_ci1",   2'b10, 4'hF, 4'hF, 1'b1, {4'hF, 4'b1010});
        apply("sub_0_f_ci0",   2'b00, 4'hF, 4'h0, 1'b0, {4'h0, 4'b0001});
        apply("sub_7_0_ci1",   2'b00, 4'h0, 4'h7, 1'b1, {4'h7, 4'b1000});
        apply("sub_8_1_ovf",   2'b00, 4'h1, 4'h8, 1'b1, {4'h7, 4'b1100});
        apply("add_ci_only",   2'b10, 4'h0, 4'h0, 1'b1, {4'h1, 4'b0000});

        // Inputs changed between edges must not reach the outputs.
        apply("hold_setup",    2'b10, 4'hF, 4'hF, 1'b1, {4'hF, 4'b1010});
        drive(2'b01, 4'h3, 4'h3, 1'b0);
        #2;
        check("hold_between_edges", outs(), {4'hF, 4'b1010});

        // Async reset while outputs are nonzero: clears without a clock edge.
        @(negedge clk);
        drive(2'b10, 4'h7, 4'h1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_clear", outs(), 8'h00);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", outs(), 8'h00);

        // The first edge after release registers the inputs present then.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_release", outs(), {4'h8, 4'b0110});

        apply("after_release_sub", 2'b00, 4'h2, 4'h4, 1'b1, {4'h2, 4'b1000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
